// File: rtl/dense_serial_mac_if.sv
// Bundle between the layer controller (master) and dense_serial_mac (slave).
// Handshake: the master raises start for at least one cycle while busy is low
// and holds x/w/b stable until done; start while busy is ignored. done is a
// one-cycle pulse at completion, valid stays high from done until the next
// accepted start or reset, and only valid qualifies the y vector.
// state mirrors the internal FSM register for observation.
interface dense_serial_mac_if #(
    parameter int BITSIZE = 16,
    parameter int N_IN    = 6,
    parameter int N_OUT   = 1
);
    logic                            start;
    logic [BITSIZE*N_IN-1:0]         x;
    logic [BITSIZE*N_IN*N_OUT-1:0]   w;
    logic [BITSIZE*N_OUT-1:0]        b;
    logic                            busy;
    logic                            done;
    logic                            valid;
    logic [BITSIZE*N_OUT-1:0]        y;
    logic [1:0]                      state;

    modport master (output start, x, w, b, input busy, done, valid, y, state);
    modport slave  (input start, x, w, b, output busy, done, valid, y, state);
endinterface

// File: rtl/dense_serial_mac.sv
// Time-multiplexed fixed-point dense layer: one multiplier and one saturating
// adder evaluate y[o] = act(b[o] + sum_i x[i]*w[o][i]) one product per cycle.
// The product is registered, so accumulation lags one cycle and the writeback
// cycle folds in the final product.
module dense_serial_mac #(
    parameter int BITSIZE = 16,
    parameter int FRAC    = 8,
    parameter int N_IN    = 6,
    parameter int N_OUT   = 1,
    parameter int RELU    = 0
) (
    input logic             clk,
    input logic             reset,
    dense_serial_mac_if.slave bus
);
    localparam int IW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int OW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [IW-1:0] LAST_I = IW'(N_IN - 1);
    localparam logic [OW-1:0] LAST_O = OW'(N_OUT - 1);
    localparam logic signed [BITSIZE-1:0] SAT_MAX = {1'b0, {(BITSIZE-1){1'b1}}};
    localparam logic signed [BITSIZE-1:0] SAT_MIN = {1'b1, {(BITSIZE-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic signed [BITSIZE-1:0]  acc_q, prod_q;
    logic                       prod_v_q;
    logic [IW-1:0]              i_q;
    logic [OW-1:0]              o_q, o_nxt;
    logic [BITSIZE*N_OUT-1:0]   y_q;
    logic                       done_q, valid_q;
    logic signed [BITSIZE-1:0]  x_sel, w_sel, b_first, b_next;
    logic signed [BITSIZE-1:0]  mul_res, acc_sum, wb_val;

    // Full-precision product, arithmetic shift (floor), clamp to word range.
    function automatic logic signed [BITSIZE-1:0] sat_mul(
        input logic signed [BITSIZE-1:0] a,
        input logic signed [BITSIZE-1:0] c
    );
        logic signed [2*BITSIZE-1:0] ae, ce, p;
        ae = {{BITSIZE{a[BITSIZE-1]}}, a};
        ce = {{BITSIZE{c[BITSIZE-1]}}, c};
        p  = ae * ce;
        p  = p >>> FRAC;
        if ((&p[2*BITSIZE-1:BITSIZE-1]) || !(|p[2*BITSIZE-1:BITSIZE-1]))
            return p[BITSIZE-1:0];
        else if (p[2*BITSIZE-1])
            return SAT_MIN;
        else
            return SAT_MAX;
    endfunction

    // One-bit-wider sum; overflow shows as disagreement of the top two bits.
    function automatic logic signed [BITSIZE-1:0] sat_add(
        input logic signed [BITSIZE-1:0] a,
        input logic signed [BITSIZE-1:0] c
    );
        logic signed [BITSIZE:0] s;
        s = {a[BITSIZE-1], a} + {c[BITSIZE-1], c};
        if (s[BITSIZE] == s[BITSIZE-1])
            return s[BITSIZE-1:0];
        else if (s[BITSIZE])
            return SAT_MIN;
        else
            return SAT_MAX;
    endfunction

    function automatic logic signed [BITSIZE-1:0] act(input logic signed [BITSIZE-1:0] v);
        if (RELU != 0 && v[BITSIZE-1])
            return '0;
        else
            return v;
    endfunction

    // Operand selection and arithmetic for the current (o, i) position.
    always_comb begin
        o_nxt   = (o_q == LAST_O) ? o_q : o_q + OW'(1);
        x_sel   = bus.x[int'(i_q)*BITSIZE +: BITSIZE];
        w_sel   = bus.w[(int'(o_q)*N_IN + int'(i_q))*BITSIZE +: BITSIZE];
        b_first = bus.b[0 +: BITSIZE];
        b_next  = bus.b[int'(o_nxt)*BITSIZE +: BITSIZE];
        mul_res = sat_mul(x_sel, w_sel);
        acc_sum = sat_add(acc_q, prod_q);
        wb_val  = act(acc_sum);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state: one MAC pass of N_IN cycles plus one writeback per neuron.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = MAC;
            MAC:     if (i_q == LAST_I) state_d = WB;
            WB:      state_d = (o_q == LAST_O) ? IDLE : MAC;
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers: counters, pipelined product, accumulator, results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            prod_q   <= '0;
            prod_v_q <= 1'b0;
            i_q      <= '0;
            o_q      <= '0;
            y_q      <= '0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        o_q      <= '0;
                        i_q      <= '0;
                        acc_q    <= b_first;
                        prod_v_q <= 1'b0;
                        valid_q  <= 1'b0;
                    end
                end
                MAC: begin
                    prod_q   <= mul_res;
                    prod_v_q <= 1'b1;
                    if (prod_v_q) acc_q <= acc_sum;
                    i_q <= i_q + IW'(1);
                end
                WB: begin
                    y_q[int'(o_q)*BITSIZE +: BITSIZE] <= wb_val;
                    if (o_q != LAST_O) begin
                        o_q      <= o_nxt;
                        i_q      <= '0;
                        acc_q    <= b_next;
                        prod_v_q <= 1'b0;
                    end else begin
                        done_q  <= 1'b1;
                        valid_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = done_q;
    assign bus.valid = valid_q;
    assign bus.y     = y_q;
    assign bus.state = state_q;
endmodule

// File: tb/tb_dense_serial_mac.sv
// Bench for dense_serial_mac: three instances (defaults, ReLU, 4x3 layer).
// Drivers push expected y and expected done cycle; per-instance monitors pop
// and compare whenever done is presented.
module tb_dense_serial_mac;
    logic clk = 1'b0;
    logic rst_a, rst_r, rst_m;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    logic [15:0] qa_y[$];
    int          qa_t[$];
    logic [15:0] qr_y[$];
    int          qr_t[$];
    logic [47:0] qm_y[$];
    int          qm_t[$];

    // Clock and edge counter (read only at negedges).
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dense_serial_mac_if #(.BITSIZE(16), .N_IN(6), .N_OUT(1)) if_a ();
    dense_serial_mac_if #(.BITSIZE(16), .N_IN(6), .N_OUT(1)) if_r ();
    dense_serial_mac_if #(.BITSIZE(16), .N_IN(4), .N_OUT(3)) if_m ();

    assign if_r.start = if_a.start;
    assign if_r.x     = if_a.x;
    assign if_r.w     = if_a.w;
    assign if_r.b     = if_a.b;

    dense_serial_mac #(.BITSIZE(16), .FRAC(8), .N_IN(6), .N_OUT(1), .RELU(0))
        u_a (.clk(clk), .reset(rst_a), .bus(if_a.slave));
    dense_serial_mac #(.BITSIZE(16), .FRAC(8), .N_IN(6), .N_OUT(1), .RELU(1))
        u_r (.clk(clk), .reset(rst_r), .bus(if_r.slave));
    dense_serial_mac #(.BITSIZE(16), .FRAC(8), .N_IN(4), .N_OUT(3), .RELU(0))
        u_m (.clk(clk), .reset(rst_m), .bus(if_m.slave));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] relu16(input logic [15:0] v);
        return v[15] ? 16'h0000 : v;
    endfunction

    // Monitor for the default instance.
    always @(negedge clk) begin
        if (if_a.done) begin
            if (qa_y.size() == 0) begin
                check("a_unexpected_done", 64'(if_a.done), 64'd0);
            end else begin
                check("a_y", 64'(if_a.y), 64'(qa_y.pop_front()));
                check("a_done_cycle", 64'(cyc), 64'(qa_t.pop_front()));
                check("a_valid_at_done", 64'(if_a.valid), 64'd1);
            end
        end
    end

    // Monitor for the ReLU instance.
    always @(negedge clk) begin
        if (if_r.done) begin
            if (qr_y.size() == 0) begin
                check("r_unexpected_done", 64'(if_r.done), 64'd0);
            end else begin
                check("r_y", 64'(if_r.y), 64'(qr_y.pop_front()));
                check("r_done_cycle", 64'(cyc), 64'(qr_t.pop_front()));
            end
        end
    end

    // Monitor for the multi-neuron instance.
    always @(negedge clk) begin
        if (if_m.done) begin
            if (qm_y.size() == 0) begin
                check("m_unexpected_done", 64'(if_m.done), 64'd0);
            end else begin
                check("m_y", 64'(if_m.y), 64'(qm_y.pop_front()));
                check("m_done_cycle", 64'(cyc), 64'(qm_t.pop_front()));
                check("m_busy_at_done", 64'(if_m.busy), 64'd0);
            end
        end
    end

    task automatic push_ar(input logic [15:0] ey, input int t, input bit expect_a);
        if (expect_a) begin
            qa_y.push_back(ey);
            qa_t.push_back(t);
        end
        qr_y.push_back(relu16(ey));
        qr_t.push_back(t);
    endtask

    // Called at a negedge: the next edge samples start, done follows 7 edges later.
    task automatic start_a(input logic [15:0] xv, input logic [15:0] wv, input logic [15:0] bv,
                           input logic [15:0] ey, input bit expect_a);
        if_a.x     = {6{xv}};
        if_a.w     = {6{wv}};
        if_a.b     = bv;
        if_a.start = 1'b1;
        push_ar(ey, cyc + 8, expect_a);
        @(negedge clk);
        if_a.start = 1'b0;
        check("a_busy_after_start", 64'(if_a.busy), 64'd1);
        check("a_valid_cleared", 64'(if_a.valid), 64'd0);
    endtask

    task automatic wait_done_a();
        int n = 0;
        while (!if_a.done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!if_a.done) begin
            check("a_done_timeout", 64'(if_a.done), 64'd1);
            qa_y.delete(); qa_t.delete(); qr_y.delete(); qr_t.delete();
        end
        @(negedge clk);
    endtask

    task automatic start_m(input logic [63:0] xv, input logic [191:0] wv, input logic [47:0] bv,
                           input logic [47:0] ey);
        if_m.x     = xv;
        if_m.w     = wv;
        if_m.b     = bv;
        if_m.start = 1'b1;
        qm_y.push_back(ey);
        qm_t.push_back(cyc + 16);
        @(negedge clk);
        if_m.start = 1'b0;
    endtask

    task automatic wait_done_m();
        int n = 0;
        while (!if_m.done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!if_m.done) begin
            check("m_done_timeout", 64'(if_m.done), 64'd1);
            qm_y.delete(); qm_t.delete();
        end
        @(negedge clk);
    endtask

    logic [15:0] vx[6] = '{16'h0100, 16'h7FFF, 16'h7FFF, 16'h0100, 16'h0180, 16'h0001};
    logic [15:0] vw[6] = '{16'h0080, 16'h7FFF, 16'h8001, 16'hFF00, 16'h0200, 16'hFF80};
    logic [15:0] vb[6] = '{16'h0040, 16'h7FFF, 16'h0000, 16'h0000, 16'hFF80, 16'h0000};
    logic [15:0] vy[6] = '{16'h0340, 16'h7FFF, 16'h8000, 16'hFA00, 16'h1180, 16'hFFFA};

    // Directed sequence.
    initial begin
        int k;
        rst_a = 1'b1; rst_r = 1'b1; rst_m = 1'b1;
        if_a.start = 1'b0; if_a.x = '0; if_a.w = '0; if_a.b = '0;
        if_m.start = 1'b0; if_m.x = '0; if_m.w = '0; if_m.b = '0;
        repeat (2) @(negedge clk);
        check("reset_a_busy", 64'(if_a.busy), 64'd0);
        check("reset_a_done", 64'(if_a.done), 64'd0);
        check("reset_a_valid", 64'(if_a.valid), 64'd0);
        check("reset_a_y", 64'(if_a.y), 64'd0);
        check("reset_m_busy", 64'(if_m.busy), 64'd0);
        check("reset_m_y", 64'(if_m.y), 64'd0);
        rst_a = 1'b0; rst_r = 1'b0; rst_m = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            start_a(vx[v], vw[v], vb[v], vy[v], 1'b1);
            wait_done_a();
            if (v == 0) begin
                repeat (3) @(negedge clk);
                check("a_valid_holds", 64'(if_a.valid), 64'd1);
                check("a_y_holds", 64'(if_a.y), 64'h0340);
            end
        end

        // Second start pulse mid-run has no effect on result or latency.
        start_a(vx[3], vw[3], vb[3], vy[3], 1'b1);
        repeat (2) @(negedge clk);
        if_a.start = 1'b1;
        @(negedge clk);
        if_a.start = 1'b0;
        wait_done_a();

        // Start held through done: back-to-back run accepted with no gap.
        if_a.x = {6{vx[3]}}; if_a.w = {6{vw[3]}}; if_a.b = vb[3];
        if_a.start = 1'b1;
        push_ar(vy[3], cyc + 8, 1'b1);
        k = 0;
        @(negedge clk);
        while (!if_a.done && k < 200) begin
            @(negedge clk);
            k++;
        end
        if_a.x = {6{vx[0]}}; if_a.w = {6{vw[0]}}; if_a.b = vb[0];
        push_ar(vy[0], cyc + 8, 1'b1);
        @(negedge clk);
        if_a.start = 1'b0;
        check("a_b2b_busy", 64'(if_a.busy), 64'd1);
        wait_done_a();

        // Reset at edge 3 of a run aborts immediately without a done pulse.
        start_a(vx[3], vw[3], vb[3], vy[3], 1'b0);
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        #1;
        check("abort_busy", 64'(if_a.busy), 64'd0);
        check("abort_valid", 64'(if_a.valid), 64'd0);
        check("abort_done", 64'(if_a.done), 64'd0);
        check("abort_y", 64'(if_a.y), 64'd0);
        @(negedge clk);
        rst_a = 1'b0;
        repeat (8) @(negedge clk);
        start_a(vx[0], vw[0], vb[0], vy[0], 1'b1);
        wait_done_a();

        // Multi-neuron layer, 4 inputs x 3 neurons.
        start_m({16'h0400, 16'h0300, 16'h0200, 16'h0100},
                {16'h0000, 16'h0000, 16'h0000, 16'h0100, 64'h0, {4{16'h0100}}},
                {16'hFF00, 16'h0080, 16'h0000},
                {16'h0000, 16'h0080, 16'h0A00});
        wait_done_m();
        start_m({16'h0400, 16'h0300, 16'h0200, 16'h0100},
                {12{16'hFF00}},
                {16'h0000, 16'h0000, 16'h0100},
                {16'hF600, 16'hF600, 16'hF700});
        wait_done_m();

        repeat (4) @(negedge clk);
        check("a_queue_drained", 64'(qa_y.size()), 64'd0);
        check("r_queue_drained", 64'(qr_y.size()), 64'd0);
        check("m_queue_drained", 64'(qm_y.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
